// File: rtl/pix_buff_pkg.sv
// Shared defaults for the pix_buff FWFT pixel buffer.
// Holds parameter defaults and the level-width helper.
package pix_buff_pkg;

  localparam int DEF_DATA_W   = 240;
  localparam int DEF_DEPTH_W  = 5;
  localparam int DEF_AF_LEVEL = 28;
  localparam int DEF_AE_LEVEL = 2;

  // level spans 0..2^depth_w+1, which fits in depth_w+1 bits
  function automatic int lvl_w(input int depth_w);
    return depth_w + 1;
  endfunction

endpackage

// File: rtl/pix_buff_ram.sv
// 2^DEPTH_W x DATA_W register array.
// Ports: clk, we/waddr/wdata sync write, raddr/rdata async read.
module pix_buff_ram #(
  parameter int DATA_W  = 240,
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pix_buff_fwft.sv
// Single-clock FWFT pixel buffer: array plus prefetch register.
// Ports: clk, rst_n, flush, wr_en/wr_data/wr_vld, rd_en/rd_data/rd_vld,
//        level, almost_full/almost_empty, sticky overflow/underflow.
module pix_buff_fwft
  import pix_buff_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH_W  = DEF_DEPTH_W,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_vld,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_vld,
  output logic [lvl_w(DEPTH_W)-1:0] level,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int LW = lvl_w(DEPTH_W);
  localparam logic [DEPTH_W:0] FULL = {1'b1, {DEPTH_W{1'b0}}};

  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   cnt;
  logic [DATA_W-1:0]  ram_q;
  logic               wr_acc;
  logic               pop;
  logic               load;

  assign wr_vld = (cnt != FULL);
  assign wr_acc = wr_en & wr_vld & ~flush;
  assign pop    = rd_en & rd_vld & ~flush;
  // refill the head whenever it is empty or being consumed
  assign load   = (cnt != '0) & (~rd_vld | pop) & ~flush;

  pix_buff_ram #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_vld    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_vld    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_vld <= 1'b1;
      end else if (pop) begin
        rd_vld <= 1'b0;
      end
      unique case (1'b1)
        (wr_acc & ~load): cnt <= cnt + 1'b1;
        (load & ~wr_acc): cnt <= cnt - 1'b1;
        default:          cnt <= cnt;
      endcase
      if (wr_en & ~wr_vld) overflow  <= 1'b1;
      if (rd_en & ~rd_vld) underflow <= 1'b1;
    end
  end

  // head data survives flush; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= ram_q;
    end
  end

  assign level = cnt + {{DEPTH_W{1'b0}}, rd_vld};
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign almost_empty = (level <= LW'(AE_LEVEL));

endmodule

// File: tb/tb_pix_buff_fwft.sv
// Self-checking bench for pix_buff_fwft.
// Vector table, directed corner sequences and a queue-based model.
module tb_pix_buff_fwft;

  localparam int DW  = 16;
  localparam int DPW = 5;
  localparam int CAP = 1 << DPW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic [DPW:0]  level;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pix_buff_fwft #(
    .DATA_W   (DW),
    .DEPTH_W  (DPW),
    .AF_LEVEL (28),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_vld       (wr_vld),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // model: array queue behind a one-entry head slot
  logic [DW-1:0] mq [$];
  logic          mhv;
  logic [DW-1:0] mhd;
  logic          mov;
  logic          mun;

  function automatic void chk(string nm, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    mq.delete();
    mhv = 1'b0;
    mhd = '0;
    mov = 1'b0;
    mun = 1'b0;
  endfunction

  function automatic void m_step(logic f, logic we,
                                 logic re, logic [DW-1:0] d);
    bit wv;
    bit pp;
    if (f) begin
      mq.delete();
      mhv = 1'b0;
      mov = 1'b0;
      mun = 1'b0;
      return;
    end
    wv = (mq.size() != CAP);
    pp = re && mhv;
    if (we && !wv) mov = 1'b1;
    if (re && !mhv) mun = 1'b1;
    if (mq.size() > 0 && (!mhv || pp)) begin
      mhd = mq.pop_front();
      mhv = 1'b1;
    end else if (pp) begin
      mhv = 1'b0;
    end
    if (we && wv) mq.push_back(d);
  endfunction

  function automatic void m_cmp();
    int lv;
    lv = mq.size() + int'(mhv);
    chk("level", int'(level), lv);
    chk("rd_vld", int'(rd_vld), int'(mhv));
    chk("rd_data", int'(rd_data), int'(mhd));
    chk("wr_vld", int'(wr_vld), int'(mq.size() != CAP));
    chk("almost_full", int'(almost_full), int'(lv >= 28));
    chk("almost_empty", int'(almost_empty), int'(lv <= 2));
    chk("overflow", int'(overflow), int'(mov));
    chk("underflow", int'(underflow), int'(mun));
  endfunction

  task automatic cyc(input logic f, input logic we,
                     input logic re, input logic [DW-1:0] d);
    flush   = f;
    wr_en   = we;
    rd_en   = re;
    wr_data = d;
    @(negedge clk);
    m_cmp();
    m_step(f, we, re, d);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          f;
    logic          we;
    logic          re;
    logic [DW-1:0] d;
    int            lv;
    logic          rv;
    logic [DW-1:0] rdd;
    logic          wv;
    logic          ae;
    logic          af;
    logic          ov;
    logic          un;
  } vec_t;

  vec_t vt [10];

  initial begin
    int exp_v;
    bit stall;
    vt[0] = '{0, 1, 0, 16'hA5, 0, 0, 16'h00, 1, 1, 0, 0, 0};
    vt[1] = '{0, 0, 0, 16'h00, 1, 0, 16'h00, 1, 1, 0, 0, 0};
    vt[2] = '{0, 0, 1, 16'h00, 1, 1, 16'hA5, 1, 1, 0, 0, 0};
    vt[3] = '{0, 0, 0, 16'h00, 0, 0, 16'hA5, 1, 1, 0, 0, 0};
    vt[4] = '{0, 0, 1, 16'h00, 0, 0, 16'hA5, 1, 1, 0, 0, 0};
    vt[5] = '{0, 1, 0, 16'h3C, 0, 0, 16'hA5, 1, 1, 0, 0, 1};
    vt[6] = '{0, 0, 0, 16'h00, 1, 0, 16'hA5, 1, 1, 0, 0, 1};
    vt[7] = '{0, 0, 1, 16'h00, 1, 1, 16'h3C, 1, 1, 0, 0, 1};
    vt[8] = '{1, 0, 0, 16'h00, 0, 0, 16'h3C, 1, 1, 0, 0, 1};
    vt[9] = '{0, 0, 0, 16'h00, 0, 0, 16'h3C, 1, 1, 0, 0, 0};

    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write latency, empty pop, flush clearing underflow
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d.level", i), int'(level), vt[i].lv);
      chk($sformatf("vec%0d.rd_vld", i), int'(rd_vld), int'(vt[i].rv));
      chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vt[i].rdd));
      chk($sformatf("vec%0d.wr_vld", i), int'(wr_vld), int'(vt[i].wv));
      chk($sformatf("vec%0d.ae", i), int'(almost_empty), int'(vt[i].ae));
      chk($sformatf("vec%0d.af", i), int'(almost_full), int'(vt[i].af));
      chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(vt[i].ov));
      chk($sformatf("vec%0d.unf", i), int'(underflow), int'(vt[i].un));
      cyc(vt[i].f, vt[i].we, vt[i].re, vt[i].d);
    end

    // fill to capacity, overflow, ordered drain
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 33; i++) cyc(0, 1, 0, DW'(i));
    chk("fill.level", int'(level), 33);
    chk("fill.wr_vld", int'(wr_vld), 0);
    chk("fill.af", int'(almost_full), 1);
    chk("fill.ovf", int'(overflow), 0);
    cyc(0, 1, 0, 16'd33);
    chk("ovf.set", int'(overflow), 1);
    chk("ovf.level", int'(level), 33);
    for (int i = 0; i < 33; i++) begin
      chk("drain.rd_vld", int'(rd_vld), 1);
      chk("drain.rd_data", int'(rd_data), i);
      cyc(0, 0, 1, 0);
    end
    chk("drain.level", int'(level), 0);

    // steady stream at level 5
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, DW'(100 + i));
    exp_v = 100;
    stall = 0;
    for (int i = 0; i < 24; i++) begin
      if (!rd_vld || level != 5) stall = 1;
      chk("stream.data", int'(rd_data), exp_v);
      cyc(0, 1, 1, DW'(105 + i));
      exp_v++;
    end
    chk("stream.no_bubble", int'(stall), 0);
    chk("stream.level", int'(level), 5);

    // flush with concurrent write
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, DW'(200 + i));
    chk("preflush.level", int'(level), 10);
    cyc(1, 1, 0, 16'd999);
    chk("flush.level", int'(level), 0);
    chk("flush.rd_vld", int'(rd_vld), 0);
    chk("flush.wr_vld", int'(wr_vld), 1);
    chk("flush.ovf", int'(overflow), 0);
    cyc(0, 1, 0, 16'd7);
    chk("post.rv_n1", int'(rd_vld), 0);
    cyc(0, 0, 0, 0);
    chk("post.rv_n2", int'(rd_vld), 1);
    chk("post.data", int'(rd_data), 7);

    // randomized traffic with varying pressure
    for (int ph = 0; ph < 6; ph++) begin
      int pw;
      int pr;
      pw = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 50);
      pr = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 85 : 50);
      for (int i = 0; i < 400; i++) begin
        cyc($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < pr,
            DW'($urandom));
      end
    end

    // async reset mid-traffic
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, DW'(300 + i));
    cyc(0, 0, 1, 0);
    chk("prerst.level", int'(level), 7);
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst.wr_vld", int'(wr_vld), 1);
    chk("rst.rd_vld", int'(rd_vld), 0);
    chk("rst.level", int'(level), 0);
    chk("rst.rd_data", int'(rd_data), 0);
    chk("rst.ae", int'(almost_empty), 1);
    chk("rst.ovf", int'(overflow), 0);
    chk("rst.unf", int'(underflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
